// File: rtl/pe_link_pkg.sv
// Shared definitions for the 130-bit nearest-neighbour PE link: bit
// positions on the forward and reverse buses, the transmit FSM state type
// and the link-word pack helper.
package pe_link_pkg;

    localparam int unsigned DATA_W         = 128;
    localparam int unsigned LINK_W         = DATA_W + 2;
    localparam int unsigned LINK_VALID_BIT = 129;
    localparam int unsigned LINK_LAST_BIT  = 128;
    localparam int unsigned CREDIT_RET_BIT = 129;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } link_state_t;

    // Build a forward link word {valid, last, data}.
    function automatic logic [LINK_W-1:0] pack_link(
        input logic              valid,
        input logic              last,
        input logic [DATA_W-1:0] data
    );
        logic [LINK_W-1:0] w_word;
        w_word                 = '0;
        w_word[LINK_VALID_BIT] = valid;
        w_word[LINK_LAST_BIT]  = last;
        w_word[DATA_W-1:0]     = data;
        return w_word;
    endfunction

endpackage

// File: rtl/pe_link_fifo.sv
// Synchronous FIFO, depth 2**AW, first-word fall-through read port.
// Ports:
//   clk, i_reset      : clock, synchronous active-high reset
//   i_wr_en/i_wr_data : push (ignored while full)
//   i_rd_en           : pop (ignored while empty); read and write may coincide
//   o_rd_data_c       : head entry, combinational from registered pointer
//   o_full/o_empty    : registered occupancy flags
module pe_link_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned W  = 129
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data_c,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic [AW:0]   w_count_next;
    logic          w_wr;
    logic          w_rd;

    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && !r_empty;

    // Occupancy after this edge; flags are registered from it.
    always_comb begin
        w_count_next = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == (AW+1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage is not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;

endmodule

// File: rtl/pe_link_tx.sv
// Transmit end of the PE link: buffers a local valid/ready word stream and
// emits registered link words under credit-based flow control, gated by
// ap_start.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ap_start              : level-sensitive transmit enable
//   din/din_last/din_valid: local word stream, din_ready accepts it
//   out_to_link           : registered {valid, last, data}
//   in_from_link          : reverse bus, only the credit-return bit is used
//   credit_count          : credits currently available
//   credit_err            : sticky, credit returned while already full
//   busy                  : started and (FIFO non-empty or credits outstanding)
module pe_link_tx
    import pe_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned LINK_WIDTH   = 130,
    parameter int unsigned FIFO_AW      = 3,
    parameter int unsigned INIT_CREDITS = 4,
    parameter int unsigned CREDIT_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_last,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [LINK_WIDTH-1:0] out_to_link,
    input  logic [LINK_WIDTH-1:0] in_from_link,
    output logic [CREDIT_W-1:0]   credit_count,
    output logic                  credit_err,
    output logic                  busy
);

    localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);

    link_state_t             r_state;
    link_state_t             w_state_next;
    logic [LINK_WIDTH-1:0]   r_link;
    logic [CREDIT_W-1:0]     r_credit;
    logic                    r_credit_err;

    logic                    w_send;
    logic                    w_ret;
    logic                    w_wr;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [DATA_WIDTH:0]     w_rd_word;
    logic [CREDIT_W:0]       w_credit_sum;
    logic [CREDIT_W-1:0]     w_credit_next;
    logic                    w_err_set;
    logic                    w_unused_link;

    // Only the credit-return bit of the reverse bus carries meaning here.
    assign w_unused_link = ^in_from_link[CREDIT_RET_BIT-1:0];

    assign w_wr = din_valid && din_ready;

    pe_link_fifo #(
        .AW (FIFO_AW),
        .W  (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .i_reset     (reset),
        .i_wr_en     (w_wr),
        .i_wr_data   ({din_last, din}),
        .i_rd_en     (w_send),
        .o_rd_data_c (w_rd_word),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: IDLE is left once and only re-entered through reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ap_start)  w_state_next = RUN;
            RUN:     if (!ap_start) w_state_next = PAUSE;
            PAUSE:   if (ap_start)  w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded controls; credit returns are ignored until started.
    always_comb begin
        din_ready = 1'b0;
        w_ret     = 1'b0;
        busy      = 1'b0;
        w_send    = 1'b0;
        if (r_state != IDLE) begin
            din_ready = !w_fifo_full;
            w_ret     = in_from_link[CREDIT_RET_BIT];
            busy      = !w_fifo_empty || (r_credit != INIT_C);
        end
        if (r_state == RUN) begin
            w_send = !w_fifo_empty && (r_credit != '0);
        end
    end

    // Credit arithmetic, saturating at the initial grant.
    always_comb begin
        w_credit_sum  = {1'b0, r_credit} + (CREDIT_W+1)'(w_ret) - (CREDIT_W+1)'(w_send);
        w_credit_next = (w_credit_sum > {1'b0, INIT_C}) ? INIT_C : w_credit_sum[CREDIT_W-1:0];
        w_err_set     = w_ret && !w_send && (r_credit == INIT_C);
    end

    // Link word, credit counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_link       <= '0;
            r_credit     <= '0;
            r_credit_err <= 1'b0;
        end else begin
            r_link <= w_send ? pack_link(1'b1, w_rd_word[DATA_WIDTH], w_rd_word[DATA_WIDTH-1:0])
                             : '0;
            if (r_state == IDLE) begin
                r_credit <= ap_start ? INIT_C : '0;
            end else begin
                r_credit <= w_credit_next;
            end
            if (w_err_set) r_credit_err <= 1'b1;
        end
    end

    assign out_to_link  = r_link;
    assign credit_count = r_credit;
    assign credit_err   = r_credit_err;

endmodule

// File: tb/tb_pe_link_tx.sv
// Bench for pe_link_tx: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the link transmitter.
module tb_pe_link_tx;

    localparam int unsigned DW   = 128;
    localparam int unsigned LW   = 130;
    localparam int unsigned CW   = 4;
    localparam int          INIT = 4;
    localparam int          DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ap_start;
    logic [DW-1:0] din;
    logic          din_last;
    logic          din_valid;
    logic          din_ready;
    logic [LW-1:0] out_to_link;
    logic [LW-1:0] in_from_link;
    logic [CW-1:0] credit_count;
    logic          credit_err;
    logic          busy;

    always #5 clk = ~clk;

    pe_link_tx dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .din          (din),
        .din_last     (din_last),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .out_to_link  (out_to_link),
        .in_from_link (in_from_link),
        .credit_count (credit_count),
        .credit_err   (credit_err),
        .busy         (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int sent_cnt = 0;
    int acc_cnt = 0;

    // Reference model: queue of {last,data}, started/running flags, credits.
    logic [DW:0] m_q[$];
    bit          m_started = 1'b0;
    bit          m_running = 1'b0;
    bit          m_err = 1'b0;
    int          m_credit = 0;

    logic [DW-1:0] beef = 128'hCAFE_0000_1111_2222_3333_4444_DEAD_BEEF;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive at negedge, check combinational outputs, step model, check registers.
    task automatic do_cycle(input bit rst, input bit start, input bit vld, input bit lst,
                            input logic [DW-1:0] d, input bit ret);
        logic [LW-1:0] exp_link;
        bit m_ready;
        bit acc;
        bit snd;
        @(negedge clk);
        reset        = rst;
        ap_start     = start;
        din_valid    = vld;
        din_last     = lst;
        din          = d;
        in_from_link = {ret, 1'($urandom), rand_word()};
        #1;
        m_ready = m_started && (m_q.size() < DEPTH);
        check("din_ready", LW'(din_ready), LW'(m_ready));
        check("busy", LW'(busy), LW'(m_started && (m_q.size() != 0 || m_credit != INIT)));
        if (din_ready && vld) acc_cnt++;
        acc = vld && m_ready;
        snd = m_running && (m_q.size() != 0) && (m_credit > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_started = 1'b0;
            m_running = 1'b0;
            m_err     = 1'b0;
            m_credit  = 0;
            exp_link  = '0;
        end else begin
            exp_link = snd ? {1'b1, m_q[0]} : '0;
            if (!m_started) begin
                if (start) begin
                    m_started = 1'b1;
                    m_running = 1'b1;
                    m_credit  = INIT;
                end
            end else begin
                if (ret && !snd && m_credit == INIT) m_err = 1'b1;
                m_credit = m_credit - int'(snd) + int'(ret);
                if (m_credit > INIT) m_credit = INIT;
                m_running = start;
            end
            if (snd) void'(m_q.pop_front());
            if (acc) m_q.push_back({lst, d});
        end
        check("out_to_link", out_to_link, exp_link);
        check("credit_count", LW'(credit_count), LW'(m_credit));
        check("credit_err", LW'(credit_err), LW'(m_err));
        if (out_to_link[LW-1]) sent_cnt++;
    endtask

    task automatic idle(input bit start, input bit ret);
        do_cycle(1'b0, start, 1'b0, 1'b0, '0, ret);
    endtask

    initial begin
        reset        = 1'b1;
        ap_start     = 1'b0;
        din          = '0;
        din_last     = 1'b0;
        din_valid    = 1'b0;
        in_from_link = '0;
        repeat (2) @(posedge clk);

        // Reset held with traffic offered, then idle before start.
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_word(), 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_word(), 1'b0);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1, rand_word(), 1'b1);
        check("idle_ready", LW'(din_ready), LW'(0));
        check("idle_link", out_to_link, '0);
        check("idle_credit", LW'(credit_count), LW'(0));
        check("idle_busy", LW'(busy), LW'(0));

        // Basic send.
        idle(1'b1, 1'b0);
        check("start_credit", LW'(credit_count), LW'(INIT));
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1, beef, 1'b0);
        idle(1'b1, 1'b0);
        check("basic_vl", LW'(out_to_link[LW-1:LW-2]), LW'(2'b11));
        check("basic_data", LW'(out_to_link[DW-1:0]), LW'(beef));
        check("basic_credit", LW'(credit_count), LW'(3));
        idle(1'b1, 1'b1);

        // Credit exhaustion, then two returns release the rest.
        sent_cnt = 0;
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 1'b1, (i == 5), rand_word(), 1'b0);
        repeat (3) idle(1'b1, 1'b0);
        check("exh_sent", LW'(sent_cnt), LW'(4));
        check("exh_credit", LW'(credit_count), LW'(0));
        sent_cnt = 0;
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        repeat (2) idle(1'b1, 1'b0);
        check("exh_rest_sent", LW'(sent_cnt), LW'(2));
        check("exh_rest_credit", LW'(credit_count), LW'(0));

        // Send and return in the same cycle keep the count steady.
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word(), 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1, 1'b1, i[0], rand_word(), 1'b1);
            check("steady_valid", LW'(out_to_link[LW-1]), LW'(1));
            check("steady_credit", LW'(credit_count), LW'(2));
        end
        idle(1'b1, 1'b1);
        check("steady_tail", LW'(credit_count), LW'(2));
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("full_credit", LW'(credit_count), LW'(INIT));
        check("no_err_yet", LW'(credit_err), LW'(0));
        idle(1'b1, 1'b1);
        check("over_err", LW'(credit_err), LW'(1));
        check("over_credit", LW'(credit_count), LW'(INIT));

        // Pause: the FIFO fills to exactly eight words with nothing sent.
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word(), 1'b0);
        idle(1'b0, 1'b0);
        acc_cnt  = 0;
        sent_cnt = 0;
        for (int i = 0; i < 12 && din_ready; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'($urandom), rand_word(), 1'b0);
        check("pause_accepted", LW'(acc_cnt), LW'(8));
        check("pause_sent", LW'(sent_cnt), LW'(0));
        for (int i = 0; i < 12; i++) idle(1'b1, 1'b1);
        check("resume_sent", LW'(sent_cnt), LW'(8));

        // Reset mid-stream with three queued words and one credit.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b1, 1'b0, rand_word(), 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, rand_word(), 1'b0);
        check("pre_rst_credit", LW'(credit_count), LW'(1));
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, rand_word(), 1'b1);
        check("rst_link", out_to_link, '0);
        check("rst_credit", LW'(credit_count), LW'(0));
        check("rst_ready", LW'(din_ready), LW'(0));
        check("rst_busy", LW'(busy), LW'(0));
        sent_cnt = 0;
        repeat (4) idle(1'b1, 1'b0);
        check("rst_fifo_empty", LW'(sent_cnt), LW'(0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 2) != 0), 1'($urandom), rand_word(),
                     ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
